// File: rtl/cipher_pkg.sv
// Shared types and constants for the byte-stream cipher.
package cipher_pkg;

  localparam int KEY_W  = 32;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  localparam logic [KEY_W-1:0] POLY         = 32'h80200003;
  // An all-zero Galois LFSR never leaves zero, so a zero key is replaced by this seed.
  localparam logic [KEY_W-1:0] DEFAULT_SEED = 32'h00000001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } cipher_state_t;

  // One right-shift Galois step: feedback taps are applied when the bit shifted out is 1.
  function automatic logic [KEY_W-1:0] lfsr_step(input logic [KEY_W-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY : {KEY_W{1'b0}});
  endfunction

endpackage

// File: rtl/keystream_lfsr.sv
// Keystream generator: owns the Galois LFSR register.
module keystream_lfsr
  import cipher_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [KEY_W-1:0] seed,
  input  logic             advance,
  output logic [KEY_W-1:0] state
);

  logic [KEY_W-1:0] lfsr_d;
  logic [KEY_W-1:0] lfsr_q;

  // Next state: a load wins over an advance; otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = seed;
    end else if (advance) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  // LFSR register, cleared by reset so the keystream restarts at the next seed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/stream_cipher_core.sv
// Byte-stream XOR cipher: session FSM, valid/ready handshake, one-entry
// output register and processed-byte counter. Encrypt and decrypt are identical.
//
//  state | meaning
//  IDLE  | waiting for op_en
//  SEED  | load LFSR from key (or default seed), clear byte counter
//  RUN   | accepting and processing bytes
//  DRAIN | op_en dropped; no new input, wait for pending output to leave
module stream_cipher_core
  import cipher_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              op_en,
  input  logic [KEY_W-1:0]  key,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  byte_count
);

  cipher_state_t     state_d, state_q;
  logic [DATA_W-1:0] out_data_d, out_data_q;
  logic              out_valid_d, out_valid_q;
  logic [CNT_W-1:0]  byte_count_d, byte_count_q;

  logic              accept;
  logic              pop;
  logic              lfsr_load;
  logic [KEY_W-1:0]  lfsr_seed;
  logic [KEY_W-1:0]  lfsr_state;

  // Handshake qualifiers; input is only taken when the output slot is free or leaving.
  always_comb begin
    in_ready  = (state_q == RUN) && (!out_valid_q || out_ready);
    accept    = in_valid && in_ready;
    pop       = out_valid_q && out_ready;
    lfsr_load = (state_q == SEED);
    lfsr_seed = (key == '0) ? DEFAULT_SEED : key;
  end

  keystream_lfsr u_keystream (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .seed    (lfsr_seed),
    .advance (accept),
    .state   (lfsr_state)
  );

  // Session sequencing, output register and counter next-state.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    byte_count_d = byte_count_q;

    unique case (state_q)
      IDLE: begin
        if (op_en) state_d = SEED;
      end
      SEED: begin
        byte_count_d = '0;
        state_d      = RUN;
      end
      RUN: begin
        // A byte accepted in the same cycle op_en falls is still processed.
        if (!op_en) state_d = DRAIN;
      end
      DRAIN: begin
        if (!out_valid_q || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_data_d   = in_data ^ lfsr_state[DATA_W-1:0];
      out_valid_d  = 1'b1;
      byte_count_d = byte_count_q + 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign byte_count = byte_count_q;
  assign busy       = (state_q != IDLE);

endmodule
